patch_window_sampler: RTL and testbench
=======================================

// Module: patch_window_sampler
// PURPOSE
//  Upstream feeder of the 16x16 RGB patch buffer. Watches the active-pixel stream from the camera/VGA path,
//  and on request picks out the WIN x WIN window whose top-left corner is (i_x0,i_y0) in the next full frame.
//  Emits exactly WIN*WIN o_take strobes with pixel data, in raster order (row 0 col 0 .. row 15 col 15).
//  The patch buffer's write counters therefore stay in lock-step with o_row/o_col.
// PARAMETERS
//  WIN    16   window edge in pixels; WIN*WIN takes per capture
//  H_ACT  800  active pixels per line; legal X = 0..H_ACT-1
//  V_ACT  600  active lines per frame; legal Y = 0..V_ACT-1
//  CW     12   coordinate width
//  PW     10   colour channel width
// PORTS
//  i_clk          in   1    pixel clock
//  i_rst_n        in   1    reset, asynchronous, active-low
//  i_start        in   1    capture request pulse; sampled only in IDLE
//  i_x0, i_y0     in   CW   requested window top-left corner
//  i_frame_start  in   1    one-cycle pulse at start of frame, >=1 cycle before first valid pixel
//  i_valid        in   1    i_X/i_Y/i_R/i_G/i_B carry an active pixel this cycle
//  i_X, i_Y       in   CW   coordinates of current pixel
//  i_R, i_G, i_B  in   PW   pixel colour
//  o_take         out  1    registered strobe: o_R/o_G/o_B hold window pixel (o_row,o_col)
//  o_R,o_G,o_B    out  PW   captured pixel colour
//  o_row, o_col   out  4    index of the pixel presented with o_take
//  o_busy         out  1    high in WAIT_FRAME and CAPTURE
//  o_done         out  1    one-cycle pulse after the 256th take
//  o_err          out  1    one-cycle pulse when a capture is aborted
// BEHAVIOUR
//  Reset: state IDLE; every output 0; internal counters and latched origin 0.
//  FSM IDLE -> WAIT_FRAME on i_start. Latch x_lo = min(i_x0, H_ACT-WIN) and y_lo = min(i_y0, V_ACT-WIN).
//   The clamp keeps the window fully on screen.
//  WAIT_FRAME -> CAPTURE on i_frame_start. Pixels seen in WAIT_FRAME are never taken,
//   including a pixel valid in the same cycle as i_frame_start.
//  CAPTURE: the expected pixel is (x_lo+col_cnt, y_lo+row_cnt), with counters starting at 0,0.
//   On i_valid with i_X/i_Y equal to the expected pixel: next cycle o_take=1 with the data,
//   o_row/o_col = the counter values used. Then col_cnt++; when col_cnt wraps 15->0, row_cnt++.
//   Only exact matches are taken. Duplicate or out-of-order pixels are ignored, and capture stalls on a skipped pixel.
//   After take 256 (row 15, col 15) -> DONE. DONE raises o_done for 1 cycle, then returns to IDLE.
//   i_frame_start in CAPTURE before take 256 -> o_err for 1 cycle, counters cleared, back to IDLE.
//   If the final match and i_frame_start arrive in the same cycle, the take wins and DONE follows (no o_err).
//  Latency: 1 cycle from a matching input pixel to o_take. o_take never asserts on two consecutive captures' boundary without an IDLE cycle.
//  i_start outside IDLE is ignored; no queuing.
//  o_R/o_G/o_B update only on take and hold their value otherwise. o_busy is combinational from state.
//  An async reset mid-capture drops everything immediately with no o_err. The patch buffer must be reset alongside.
//  Arithmetic: x_lo+col_cnt is formed in CW bits. The clamp guarantees it never exceeds H_ACT-1; the same holds for y.
// STRUCTURE
//  tracker_pkg: WIN, H_ACT, V_ACT, CW, PW constants; typedef enum {IDLE, WAIT_FRAME, CAPTURE, DONE} samp_state_t.
//  Sub-module window_clamp: combinational clamp of (i_x0,i_y0) to a legal origin, reused by the tracker overlay.
// TESTING
//  1. start, x0=100, y0=50, raster frame 800x600 -> 256 takes; first (X100,Y50) row0 col0; last (X115,Y65) row15 col15; o_done 1 cycle later.
//  2. x0=795, y0=598 -> clamped origin (784,584); first take X784 Y584, last X799 Y599.
//  3. Second i_frame_start injected after 100 takes -> o_err pulse, IDLE, o_take never asserts again, o_busy=0.
//  4. Stream skips pixel (X105,Y50) -> capture stalls at row0 col5 until the next frame start -> o_err.
//  5. i_start during CAPTURE with new x0=0 -> ignored; all takes use the original origin.
//  6. i_rst_n low at take 37 -> all outputs 0 asynchronously; a new start after release captures a full 256 from row0 col0.

Source files
------------

// File: rtl/tracker_pkg.sv
// Shared constants and state encoding for the patch-window sampler and the tracker overlay.
package tracker_pkg;

  localparam int WIN   = 16;
  localparam int H_ACT = 800;
  localparam int V_ACT = 600;
  localparam int CW    = 12;
  localparam int PW    = 10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    CAPTURE,
    DONE
  } samp_state_t;

endpackage

// File: rtl/window_clamp.sv
// Clamps a requested window origin so that a window of the given size stays fully on screen.
module window_clamp #(
  parameter int CW    = 12,
  parameter int X_MAX = 784,
  parameter int Y_MAX = 584
) (
  input  logic [CW-1:0] x_in,
  input  logic [CW-1:0] y_in,
  output logic [CW-1:0] x_out,
  output logic [CW-1:0] y_out
);

  localparam logic [CW-1:0] X_LIM = CW'(X_MAX);
  localparam logic [CW-1:0] Y_LIM = CW'(Y_MAX);

  assign x_out = (x_in > X_LIM) ? X_LIM : x_in;
  assign y_out = (y_in > Y_LIM) ? Y_LIM : y_in;

endmodule

// File: rtl/patch_window_sampler.sv
// Picks a WIN x WIN window out of the next full frame of the active-pixel stream and
// emits it in raster order, one registered o_take strobe per pixel.
module patch_window_sampler
  import tracker_pkg::*;
#(
  parameter int WIN   = tracker_pkg::WIN,
  parameter int H_ACT = tracker_pkg::H_ACT,
  parameter int V_ACT = tracker_pkg::V_ACT,
  parameter int CW    = tracker_pkg::CW,
  parameter int PW    = tracker_pkg::PW
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [CW-1:0]            i_x0,
  input  logic [CW-1:0]            i_y0,
  input  logic                     i_frame_start,
  input  logic                     i_valid,
  input  logic [CW-1:0]            i_X,
  input  logic [CW-1:0]            i_Y,
  input  logic [PW-1:0]            i_R,
  input  logic [PW-1:0]            i_G,
  input  logic [PW-1:0]            i_B,
  output logic                     o_take,
  output logic [PW-1:0]            o_R,
  output logic [PW-1:0]            o_G,
  output logic [PW-1:0]            o_B,
  output logic [$clog2(WIN)-1:0]   o_row,
  output logic [$clog2(WIN)-1:0]   o_col,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err
);

  localparam int IW = $clog2(WIN);
  localparam logic [IW-1:0] LAST = IW'(WIN - 1);

  samp_state_t   state_q, state_d;
  logic [CW-1:0] x_lo, y_lo;
  logic [CW-1:0] x_cl, y_cl;
  logic [IW-1:0] row_cnt, col_cnt;
  logic [CW-1:0] exp_x, exp_y;
  logic          match, last_pix, take, abort;

  window_clamp #(
    .CW    (CW),
    .X_MAX (H_ACT - WIN),
    .Y_MAX (V_ACT - WIN)
  ) u_clamp (
    .x_in  (i_x0),
    .y_in  (i_y0),
    .x_out (x_cl),
    .y_out (y_cl)
  );

  // The clamp bounds the sums to the active area, so CW bits never overflow.
  assign exp_x    = x_lo + CW'(col_cnt);
  assign exp_y    = y_lo + CW'(row_cnt);
  assign match    = i_valid && (i_X == exp_x) && (i_Y == exp_y);
  assign last_pix = (row_cnt == LAST) && (col_cnt == LAST);

  // A frame start only beats a match when the match is not the final pixel.
  assign take  = (state_q == CAPTURE) && match && (!i_frame_start || last_pix);
  assign abort = (state_q == CAPTURE) && i_frame_start && !(match && last_pix);

  assign o_busy = (state_q == WAIT_FRAME) || (state_q == CAPTURE);

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:       if (i_start) state_d = WAIT_FRAME;
      WAIT_FRAME: if (i_frame_start) state_d = CAPTURE;
      CAPTURE: begin
        if (take && last_pix) state_d = DONE;
        else if (abort)       state_d = IDLE;
      end
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: non-blocking so all registers update from the same pre-edge values.
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_lo    <= '0;
      y_lo    <= '0;
      row_cnt <= '0;
      col_cnt <= '0;
      o_take  <= 1'b0;
      o_R     <= '0;
      o_G     <= '0;
      o_B     <= '0;
      o_row   <= '0;
      o_col   <= '0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_take <= take;
      o_done <= (state_q == DONE);
      o_err  <= abort;

      if (state_q == IDLE && i_start) begin
        x_lo    <= x_cl;
        y_lo    <= y_cl;
        row_cnt <= '0;
        col_cnt <= '0;
      end

      if (take) begin
        o_R   <= i_R;
        o_G   <= i_G;
        o_B   <= i_B;
        o_row <= row_cnt;
        o_col <= col_cnt;
        if (col_cnt == LAST) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + IW'(1);
        end else begin
          col_cnt <= col_cnt + IW'(1);
        end
      end

      if (abort || state_q == DONE) begin
        row_cnt <= '0;
        col_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_patch_window_sampler.sv
// Scoreboard bench: the driver streams randomized partial frames and queues expected takes;
// a monitor pops and compares every o_take and tallies o_done/o_err pulses.
module tb_patch_window_sampler;
  import tracker_pkg::*;

  localparam int XM = H_ACT - WIN;
  localparam int YM = V_ACT - WIN;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] x0 = '0, y0 = '0;
  logic          fs = 1'b0;
  logic          valid = 1'b0;
  logic [CW-1:0] px = '0, py = '0;
  logic [PW-1:0] r = '0, g = '0, b = '0;

  logic          o_take, o_busy, o_done, o_err;
  logic [PW-1:0] o_R, o_G, o_B;
  logic [3:0]    o_row, o_col;

  patch_window_sampler dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_x0          (x0),
    .i_y0          (y0),
    .i_frame_start (fs),
    .i_valid       (valid),
    .i_X           (px),
    .i_Y           (py),
    .i_R           (r),
    .i_G           (g),
    .i_B           (b),
    .o_take        (o_take),
    .o_R           (o_R),
    .o_G           (o_G),
    .o_B           (o_B),
    .o_row         (o_row),
    .o_col         (o_col),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err         (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] r, g, b;
    int            row, col;
  } take_t;

  take_t sb[$];
  int    total = 0, bad = 0;
  int    exp_done = 0, exp_err = 0, got_done = 0, got_err = 0;
  int    m_state = 0;  // 0 idle, 1 waiting for frame, 2 capturing, 3 finishing
  int    m_idx = 0, m_ox = 0, m_oy = 0;
  bit    prev_final = 1'b0;
  take_t mon_e;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: every take must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_take) begin
        if (sb.size() == 0) begin
          check("unexpected_take", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("take_rgb", {o_R, o_G, o_B}, {mon_e.r, mon_e.g, mon_e.b});
          check("take_index", {o_row, o_col}, 64'(mon_e.row * 16 + mon_e.col));
        end
      end
      if (o_done) begin
        got_done++;
        check("done_follows_last_take", 64'(prev_final), 64'd1);
      end
      if (o_err) got_err++;
      prev_final = o_take && (o_row == 4'd15) && (o_col == 4'd15);
    end
  end

  // Drives one cycle of inputs and advances the reference model by the capture rules.
  task automatic drive(input bit v, input int x, input int y, input bit f, input bit s,
                       output bit pushed);
    take_t e;
    bit    hit;
    pushed = 1'b0;
    valid = v; px = CW'(x); py = CW'(y); fs = f; start = s;
    r = PW'($urandom); g = PW'($urandom); b = PW'($urandom);
    if (m_state == 3) begin
      m_state = 0;
    end else if (m_state == 0) begin
      if (s) begin
        m_state = 1;
        m_ox = (int'(x0) > XM) ? XM : int'(x0);
        m_oy = (int'(y0) > YM) ? YM : int'(y0);
      end
    end else if (m_state == 1) begin
      if (f) begin m_state = 2; m_idx = 0; end
    end else begin
      hit = v && (x == m_ox + m_idx % WIN) && (y == m_oy + m_idx / WIN);
      if (hit && (!f || m_idx == WIN * WIN - 1)) begin
        e.r = r; e.g = g; e.b = b; e.row = m_idx / WIN; e.col = m_idx % WIN;
        sb.push_back(e);
        pushed = 1'b1;
        m_idx++;
        if (m_idx == WIN * WIN) begin m_state = 3; exp_done++; end
      end else if (f) begin
        m_state = 0;
        exp_err++;
      end
    end
    @(posedge clk); #1;
    valid = 1'b0; fs = 1'b0; start = 1'b0;
  endtask

  task automatic idle(input int n);
    bit p;
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 1'b0, p);
  endtask

  task automatic do_start(input int sx, input int sy);
    bit p;
    x0 = CW'(sx); y0 = CW'(sy);
    drive(1'b0, 0, 0, 1'b0, 1'b1, p);
  endtask

  // Streams the lines around the model window; optional fault/event injection by take count.
  task automatic run_frame(input int fs_after, input int skip_x, input int skip_y,
                           input int start_at, input int rst_at);
    bit p;
    bit start_sent = 1'b0;
    int n = 0;
    int ylo = (m_oy - 1 < 0) ? 0 : m_oy - 1;
    int yhi = (m_oy + WIN > V_ACT - 1) ? V_ACT - 1 : m_oy + WIN;
    int xlo = (m_ox - 3 < 0) ? 0 : m_ox - 3;
    int xhi = (m_ox + WIN + 2 > H_ACT - 1) ? H_ACT - 1 : m_ox + WIN + 2;
    drive(1'b0, 0, 0, 1'b0, 1'b0, p);
    drive(1'b0, 0, 0, 1'b1, 1'b0, p);
    for (int y = ylo; y <= yhi; y++) begin
      for (int x = xlo; x <= xhi; x++) begin
        if (x == skip_x && y == skip_y) continue;
        if ($urandom_range(3) == 0) drive(1'b0, 0, 0, 1'b0, 1'b0, p);
        if (start_at >= 0 && n == start_at && !start_sent) begin
          x0 = '0; y0 = '0;
          start_sent = 1'b1;
          drive(1'b1, x, y, 1'b0, 1'b1, p);
        end else begin
          drive(1'b1, x, y, 1'b0, 1'b0, p);
        end
        n += int'(p);
        if (p && n == rst_at) begin
          @(negedge clk); #1;
          rst_n = 1'b0;
          #1;
          check("async_reset_outputs",
                {o_take, o_R, o_G, o_B, o_row, o_col, o_busy, o_done, o_err}, 64'd0);
          sb.delete();
          m_state = 0;
          prev_final = 1'b0;
          repeat (2) @(posedge clk);
          @(negedge clk); rst_n = 1'b1;
          @(posedge clk); #1;
          return;
        end
        if (p && n == fs_after) drive(1'b0, 0, 0, 1'b1, 1'b0, p);
        if ($urandom_range(9) == 0) drive(1'b1, x, y, 1'b0, 1'b0, p);
      end
    end
  endtask

  task automatic end_test(input string name);
    idle(5);
    check({name, "_done_count"}, 64'(got_done), 64'(exp_done));
    check({name, "_err_count"}, 64'(got_err), 64'(exp_err));
    check({name, "_pending_takes"}, 64'(sb.size()), 64'd0);
    check({name, "_busy_low"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {o_take, o_R, o_G, o_B, o_row, o_col, o_busy, o_done, o_err}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain capture.
    do_start(100, 50);
    check("busy_after_start", 64'(o_busy), 64'd1);
    run_frame(-1, -1, -1, -1, -1);
    end_test("basic");

    // Origin beyond the edge is clamped to (784,584).
    do_start(795, 598);
    run_frame(-1, -1, -1, -1, -1);
    end_test("clamp");

    // Early frame start aborts after 100 takes.
    do_start(300, 200);
    run_frame(100, -1, -1, -1, -1);
    end_test("abort");

    // Skipped pixel stalls the capture until the next frame start.
    do_start(420, 310);
    run_frame(-1, m_ox + 5, m_oy, -1, -1);
    check("stall_busy", 64'(o_busy), 64'd1);
    run_frame(-1, -1, -1, -1, -1);
    end_test("stall");

    // Start request mid-capture is ignored.
    do_start(640, 100);
    run_frame(-1, -1, -1, 50, -1);
    end_test("start_ignored");

    // Reset mid-capture, then a clean full capture.
    do_start(10, 20);
    run_frame(-1, -1, -1, -1, 37);
    check("reset_err_count", 64'(got_err), 64'(exp_err));
    do_start(0, 0);
    run_frame(-1, -1, -1, -1, -1);
    end_test("after_reset");

    // Random origins, including out-of-range requests.
    for (int k = 0; k < 3; k++) begin
      do_start($urandom_range(0, 900), $urandom_range(0, 700));
      run_frame(-1, -1, -1, -1, -1);
      end_test("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
